instruction_fetch_unit: RTL

Initiator side of the instruction-memory read protocol: owns the PC, drives MemAddress/MemReadEnable, waits for MemAck and captures MemInstr. It buffers fetched words in a 2-entry FIFO and hands them to decode over a valid/ready handshake. It supports branch redirect/flush and flags a sticky error when an acknowledge never arrives. It sits between the PC/branch logic and the instruction_memory responder.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues read requests to instruction
// memory, buffers returned words in a 2-entry in-order FIFO and presents them
// to decode over a valid/ready handshake. Supports redirect/flush and a
// sticky acknowledge-timeout error.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] MemAddress,
    output logic        MemReadEnable,
    input  logic        MemAck,
    input  logic [31:0] MemInstr,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        FetchError
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    // Last counter value before the timeout fires; the counter counts
    // completed cycles in FETCH without an acknowledge.
    localparam logic [7:0]  TMO_LAST         = 8'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [7:0]  tmo_q;
    logic        ren_q;
    logic        err_q;

    // FIFO storage: slot 0 is always the head, slot 1 sits behind it.
    logic [31:0] slot_instr_q [2];
    logic [31:0] slot_pc_q    [2];
    logic [1:0]  count_q;
    logic [31:0] slot_instr_d [2];
    logic [31:0] slot_pc_d    [2];
    logic [1:0]  count_d;

    logic        pop;
    logic        push;
    logic        wr_idx;

    assign pop  = (count_q != 2'd0) && InstrReady;
    assign push = (state_q == ST_FETCH) && MemAck;

    // After an optional shift-on-pop, the new word goes into the first free slot.
    assign wr_idx = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

    // FIFO next-state: shift on pop, write behind the surviving entries on push.
    always_comb begin
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        count_d      = count_q;
        if (Redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                slot_instr_d[0] = slot_instr_q[1];
                slot_pc_d[0]    = slot_pc_q[1];
            end
            if (push) begin
                slot_instr_d[wr_idx] = MemInstr;
                slot_pc_d[wr_idx]    = pc_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // FIFO registers; contents reset to zero so the head is never X.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_instr_q[0] <= '0;
            slot_instr_q[1] <= '0;
            slot_pc_q[0]    <= '0;
            slot_pc_q[1]    <= '0;
            count_q         <= 2'd0;
        end else begin
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            count_q      <= count_d;
        end
    end

    // Fetch FSM with PC, timeout counter, registered read enable and sticky error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            tmo_q   <= 8'd0;
            ren_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (Redirect) begin
            pc_q  <= {RedirectPC[31:2], 2'b00};
            tmo_q <= 8'd0;
            if (state_q != ST_ERROR) begin
                state_q <= ST_FETCH;
                ren_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_d < 2'd2) begin
                        state_q <= ST_FETCH;
                        ren_q   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (MemAck) begin
                        pc_q  <= pc_q + 32'd4;
                        tmo_q <= 8'd0;
                        if (count_d >= 2'd2) begin
                            state_q <= ST_IDLE;
                            ren_q   <= 1'b0;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_ERROR;
                        ren_q   <= 1'b0;
                        err_q   <= 1'b1;
                        tmo_q   <= 8'd0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_ERROR;
                    ren_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddress    = pc_q;
    assign MemReadEnable = ren_q;
    assign InstrValid    = (count_q != 2'd0);
    assign Instr         = slot_instr_q[0];
    assign InstrPC       = slot_pc_q[0];
    assign FetchError    = err_q;

endmodule
